// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache (1 or 2 ways, multi-word blocks)
// with LRU replacement, a flush input and a sequential refill FSM that yields the
// memory port to the data cache whenever dREN or dWEN is high.
// Optional feature macro: ICACHE_STATS_EN builds the hit/miss statistics counters;
// without it hit_count and miss_count are tied to zero.
`timescale 1ns/1ps
module icache_assoc #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    input  logic        dREN,
    input  logic        dWEN,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int OFF_B = $clog2(WORDS);
    localparam int IDX_B = $clog2(SETS);
    localparam int TAG_B = 30 - OFF_B - IDX_B;
    localparam int OFF_W = (OFF_B > 0) ? OFF_B : 1;
    localparam int BLK_W = WORDS * 32;
    // Index of the second way; collapses to way 0 when the cache is direct-mapped
    localparam logic WAY1 = (WAYS == 2);

    typedef logic [OFF_B:0]   wc_t;   // word offset plus a done/carry bit
    typedef logic [OFF_W-1:0] off_t;
    typedef logic [IDX_B-1:0] idx_t;
    typedef logic [TAG_B-1:0] tag_t;
    typedef enum logic {IDLE, REFILL} state_t;

    localparam wc_t         LAST_WC  = wc_t'(WORDS - 1);
    localparam logic [31:0] BLK_MASK = 32'(WORDS * 4 - 1);

    state_t           state;
    wc_t              wc;
    logic [31:0]      base;
    logic             victim;
    logic [SETS-1:0]  valid [WAYS];
    logic [SETS-1:0]  lru;            // per set: way to evict next
    tag_t             tag_mem  [WAYS][SETS];
    logic [BLK_W-1:0] data_mem [WAYS][SETS];
    logic [BLK_W-1:0] fill_buf;

    off_t req_off;
    idx_t req_idx;
    tag_t req_tag;
    idx_t ref_idx;
    tag_t ref_tag;

    logic hit_w0, hit_w1, any_hit, hit_way, lookup, miss, victim_sel;
    logic ren, accept, last;
    logic [BLK_W-1:0] install_blk;

    assign req_off = off_t'((imemaddr >> 2) & 32'(WORDS - 1));
    assign req_idx = idx_t'(imemaddr >> (2 + OFF_B));
    assign req_tag = tag_t'(imemaddr >> (2 + OFF_B + IDX_B));
    assign ref_idx = idx_t'(base >> (2 + OFF_B));
    assign ref_tag = tag_t'(base >> (2 + OFF_B + IDX_B));

    // Lookup: tag compare in both ways, hit word mux and victim choice for a miss
    always_comb begin
        hit_w0   = valid[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
        hit_w1   = WAY1 && valid[WAY1][req_idx] && (tag_mem[WAY1][req_idx] == req_tag);
        any_hit  = hit_w0 || hit_w1;
        hit_way  = WAY1 & hit_w1 & ~hit_w0;
        lookup   = imemREN && !flush && (state == IDLE);
        ihit     = lookup && any_hit;
        miss     = lookup && !any_hit;
        imemload = ihit ? data_mem[hit_way][req_idx][{req_off, 5'd0} +: 32] : 32'd0;
        if (!valid[0][req_idx])
            victim_sel = 1'b0;
        else if (!valid[WAY1][req_idx])
            victim_sel = WAY1;
        else
            victim_sel = WAY1 & lru[req_idx];
    end

    // Refill port: request the next block word unless the data cache owns memory
    always_comb begin
        ren         = (state == REFILL) && !dREN && !dWEN;
        accept      = ren && !iwait;
        last        = accept && (wc == LAST_WC);
        iREN        = ren;
        iaddr       = ren ? (base | ((32'(wc) & 32'(WORDS - 1)) << 2)) : 32'd0;
        install_blk = fill_buf;
        install_blk[BLK_W-32 +: 32] = iload;
    end

    // Control: FSM, word counter, valid and LRU bits (reset beats flush beats install)
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            wc    <= '0;
            lru   <= '0;
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
        end else if (flush) begin
            state <= IDLE;
            wc    <= '0;
            lru   <= '0;
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ihit)
                        lru[req_idx] <= ~hit_way;
                    if (miss) begin
                        state  <= REFILL;
                        base   <= imemaddr & ~BLK_MASK;
                        victim <= victim_sel;
                        wc     <= '0;
                    end
                end
                REFILL: begin
                    if (accept)
                        wc <= wc + wc_t'(1);
                    if (last) begin
                        valid[victim][ref_idx] <= 1'b1;
                        lru[ref_idx]           <= ~victim;
                        state                  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: gather refill words, then write tag and whole block into the victim way
    always_ff @(posedge CLK) begin
        if (accept)
            fill_buf[{off_t'(wc), 5'd0} +: 32] <= iload;
        if (last && !flush) begin
            tag_mem[victim][ref_idx]  <= ref_tag;
            data_mem[victim][ref_idx] <= install_blk;
        end
    end

`ifdef ICACHE_STATS_EN
    // Statistics: one hit per ihit cycle, one miss per IDLE->REFILL transition
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit)
                hit_count <= hit_count + 32'd1;
            if (miss)
                miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Testbench for icache_assoc: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural cache model kept in this file.
`timescale 1ns/1ps
module tb_icache_assoc;
    localparam int SETS  = 8;
    localparam int WAYS  = 2;
    localparam int WORDS = 2;
    localparam int BLK   = WORDS * 4;
`ifdef ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST, imemREN, flush, dREN, dWEN, iwait;
    logic [31:0] imemaddr, iload;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr, hit_count, miss_count;

    icache_assoc #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
        .dREN(dREN), .dWEN(dWEN), .ihit(ihit), .imemload(imemload), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Backing memory: explicit words where preloaded, a fixed hash elsewhere
    logic [31:0] mem [int unsigned];

    // Reference model: which blocks each set holds, recency, and the refill in flight
    bit          m_valid [SETS][WAYS];
    int unsigned m_blk   [SETS][WAYS];
    int          m_mru   [SETS];
    bit          m_ref;
    int unsigned m_base;
    int          m_vic;
    int unsigned m_cnt;
    int unsigned m_hits, m_miss;

    logic        o_hit, o_iren;
    logic [31:0] o_load, o_iaddr;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_mru[s] = WAYS - 1;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
        m_ref = 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at negedge, compare outputs, advance the model
    task automatic step(input bit rst_i, input bit req, input logic [31:0] a, input bit fl,
                        input bit dr, input bit dw, input bit iw, input bit do_chk);
        bit          exp_iren, exp_hit, lookup;
        logic [31:0] exp_iaddr, exp_load;
        int          s, hw, rs;
        int unsigned b;
        @(negedge CLK);
        b         = a / BLK;
        s         = int'(b % SETS);
        exp_iren  = m_ref && !dr && !dw;
        exp_iaddr = exp_iren ? (m_base + 4 * m_cnt) : 32'd0;
        lookup    = req && !fl && !m_ref;
        hw        = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_blk[s][w] == b) hw = w;
        exp_hit   = lookup && (hw >= 0);
        exp_load  = exp_hit ? mem_rd(a) : 32'd0;

        RST = rst_i; imemREN = req; imemaddr = a; flush = fl;
        dREN = dr; dWEN = dw; iwait = iw;
        iload = (exp_iren && !iw) ? mem_rd(exp_iaddr) : $urandom;
        #1;
        o_hit = ihit; o_iren = iREN; o_load = imemload; o_iaddr = iaddr;
        if (do_chk) begin
            chk("ihit",       32'(ihit),  32'(exp_hit));
            chk("imemload",   imemload,   exp_load);
            chk("iREN",       32'(iREN),  32'(exp_iren));
            chk("iaddr",      iaddr,      exp_iaddr);
            chk("hit_count",  hit_count,  STATS ? m_hits : 32'd0);
            chk("miss_count", miss_count, STATS ? m_miss : 32'd0);
        end

        if (rst_i) begin
            m_clear();
            m_hits = 0;
            m_miss = 0;
        end else if (fl) begin
            m_clear();
        end else if (!m_ref) begin
            if (lookup && hw >= 0) begin
                m_mru[s] = hw;
                m_hits++;
            end else if (lookup) begin
                m_vic = -1;
                for (int w = WAYS - 1; w >= 0; w--)
                    if (!m_valid[s][w]) m_vic = w;
                if (m_vic < 0) m_vic = (WAYS == 1) ? 0 : 1 - m_mru[s];
                m_ref  = 1'b1;
                m_base = b * BLK;
                m_cnt  = 0;
                m_miss++;
            end
        end else if (exp_iren && !iw) begin
            m_cnt++;
            if (m_cnt == WORDS) begin
                rs = int'((m_base / BLK) % SETS);
                m_valid[rs][m_vic] = 1'b1;
                m_blk[rs][m_vic]   = m_base / BLK;
                m_mru[rs]          = m_vic;
                m_ref              = 1'b0;
            end
        end
    endtask

    // Request one address until it hits, with a bounded number of cycles
    task automatic fetch(input logic [31:0] a, output bit first_hit);
        int n = 0;
        step(0, 1, a, 0, 0, 0, 0, 1);
        first_hit = o_hit;
        while (!o_hit && n < 20) begin
            step(0, 1, a, 0, 0, 0, 0, 1);
            n++;
        end
        chk("fetch_done", 32'(o_hit), 32'd1);
    endtask

    initial begin
        bit          fh;
        logic [31:0] ra;
        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; flush = 1'b0;
        dREN = 1'b0; dWEN = 1'b0; iwait = 1'b0; iload = '0;
        m_clear();
        m_hits = 0;
        m_miss = 0;
        mem[32'h40] = 32'hAAAA_0001;
        mem[32'h44] = 32'hAAAA_0002;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_iren", 32'(o_iren), 32'd0);
        chk("rst_hit",  32'(o_hit),  32'd0);

        // Cold miss on 0x40: fill 0x40/0x44, hit on cycle 4
        step(0, 1, 32'h40, 0, 0, 0, 0, 1);
        chk("cold_c1_hit", 32'(o_hit), 32'd0);
        step(0, 1, 32'h40, 0, 0, 0, 0, 1);
        chk("cold_c2_iaddr", o_iaddr, 32'h40);
        step(0, 1, 32'h40, 0, 0, 0, 0, 1);
        chk("cold_c3_iaddr", o_iaddr, 32'h44);
        step(0, 1, 32'h40, 0, 0, 0, 0, 1);
        chk("cold_c4_hit",  32'(o_hit), 32'd1);
        chk("cold_c4_load", o_load, 32'hAAAA_0001);
        step(0, 1, 32'h44, 0, 0, 0, 0, 1);
        chk("cold_w1_load", o_load, 32'hAAAA_0002);

        // Conflict and LRU in set 0
        fetch(32'h440, fh);
        chk("lru_440_miss", 32'(fh), 32'd0);
        step(0, 1, 32'h40, 0, 0, 0, 0, 1);
        chk("lru_040_hit", 32'(o_hit), 32'd1);
        fetch(32'h840, fh);
        chk("lru_840_miss", 32'(fh), 32'd0);
        step(0, 1, 32'h40, 0, 0, 0, 0, 1);
        chk("lru_040_kept", 32'(o_hit), 32'd1);
        fetch(32'h440, fh);
        chk("lru_440_evicted", 32'(fh), 32'd0);

        // Data cache takes memory for 3 cycles mid-refill
        step(0, 1, 32'hC8, 0, 0, 0, 0, 1);
        step(0, 1, 32'hC8, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'hC8, 0, 0, 1, 0, 1);
            chk("yield_iren", 32'(o_iren), 32'd0);
        end
        step(0, 1, 32'hC8, 0, 0, 0, 0, 1);
        chk("yield_resume_iaddr", o_iaddr, 32'hCC);
        step(0, 1, 32'hC8, 0, 0, 0, 0, 1);
        chk("yield_hit",  32'(o_hit), 32'd1);
        chk("yield_load", o_load, mem_rd(32'hC8));

        // Memory stalls for 5 cycles on word 1
        step(0, 1, 32'h1D4, 0, 0, 0, 0, 1);
        step(0, 1, 32'h1D4, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'h1D4, 0, 0, 0, 1, 1);
            chk("stall_iaddr", o_iaddr, 32'h1D4);
        end
        step(0, 1, 32'h1D4, 0, 0, 0, 0, 1);
        chk("stall_no_early_hit", 32'(o_hit), 32'd0);
        step(0, 1, 32'h1D4, 0, 0, 0, 0, 1);
        chk("stall_load", o_load, mem_rd(32'h1D4));

        // Flush aborts a refill; the re-request misses again
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 32'h2E0, 0, 0, 0, 0, 1);
        step(0, 1, 32'h2E0, 0, 0, 0, 0, 1);
        step(0, 1, 32'h2E0, 1, 0, 0, 0, 1);
        chk("flush_cycle_hit", 32'(o_hit), 32'd0);
        step(0, 1, 32'h2E0, 0, 0, 0, 0, 1);
        chk("flush_rereq_miss", 32'(o_hit), 32'd0);
        step(0, 1, 32'h2E0, 0, 0, 0, 0, 1);
        chk("flush_miss_count", miss_count, STATS ? 32'd2 : 32'd0);
        chk("flush_hit_count",  hit_count,  32'd0);
        fetch(32'h2E0, fh);

        // Reset in the middle of a refill
        step(0, 1, 32'h3E0, 0, 0, 0, 0, 1);
        step(0, 1, 32'h3E0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rstmid_iren", 32'(o_iren), 32'd0);
        chk("rstmid_hit",  32'(o_hit),  32'd0);
        chk("rstmid_hits", hit_count,  32'd0);
        chk("rstmid_miss", miss_count, 32'd0);
        step(0, 1, 32'h2E0, 0, 0, 0, 0, 1);
        chk("rstmid_old_miss", 32'(o_hit), 32'd0);
        fetch(32'h2E0, fh);

        // Randomized traffic over a small address pool
        for (int i = 0; i < 3000; i++) begin
            ra = $urandom & 32'h0000_10FC;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8, ra,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
